// File: rtl/timer_pkg.sv
// timer_array shared definitions: register offsets, bit indices, tap helpers.
// Used by timer_channel and timer_array.
package timer_pkg;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_SCALE = 4'h1;
  localparam logic [1:0] GRP_PRESET  = 2'd1;
  localparam logic [1:0] GRP_COMPARE = 2'd2;
  localparam logic [1:0] GRP_COUNT   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_CASCADE = 3;
  localparam int CTRL_OSCSEL  = 4;

  localparam int GLB_OSC1_EN = 0;
  localparam int GLB_OSC2_EN = 1;

  // osc1 tap widths: divisors 2,8,32,64,128,256,1024,4096
  function automatic logic [3:0] osc1_width(input logic [2:0] p);
    logic [3:0] w;
    case (p)
      3'd0:    w = 4'd1;
      3'd1:    w = 4'd3;
      3'd2:    w = 4'd5;
      3'd3:    w = 4'd6;
      3'd4:    w = 4'd7;
      3'd5:    w = 4'd8;
      3'd6:    w = 4'd10;
      default: w = 4'd12;
    endcase
    return w;
  endfunction

  function automatic logic tick_osc1(
    input logic [11:0] pre,
    input logic [2:0]  p
  );
    logic [12:0] m;
    m = (13'd1 << osc1_width(p)) - 13'd1;
    return ({1'b0, pre} & m) == m;
  endfunction

  function automatic logic tick_osc2(
    input logic [6:0] pre,
    input logic [2:0] p
  );
    logic [7:0] m;
    m = (8'd1 << p) - 8'd1;
    return ({1'b0, pre} & m) == m;
  endfunction

endpackage

// File: rtl/timer_array_if.sv
// CPU bus slave window signals for timer_array.
// master = CPU side, slave = timer block.
interface timer_array_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in,
    input  bus_data_out
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in,
    output bus_data_out
  );
endinterface

// File: rtl/timer_channel.sv
// One down-counter channel: CTRL/SCALE/PRESET/COMPARE, IRQ and tout.
// Cascade input only honoured when TIMER_CASCADE_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [3:0]       i_wr_off,
  input  logic [7:0]       i_wr_data,
  input  logic [3:0]       i_rd_off,
  output logic [7:0]       o_rd_data,
  input  logic [7:0]       i_osc1_tick,
  input  logic [7:0]       i_osc2_tick,
  input  logic             i_casc_tick,
  output logic             o_uflow,
  output logic [1:0]       o_irq,
  output logic             o_tout
);

  localparam int NB = CNT_W / 8;

  logic             r_en;
  logic             r_reload;
  logic             r_oneshot;
  logic             r_oscsel;
  logic [2:0]       r_scale;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_compare;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_irq;
  logic             r_tout;
  logic             w_casc_rd;
  logic             w_src;
  logic             w_tick;
  logic             w_uflow;
  logic             w_cmp;
  logic [7:0]       w_ctrl;
  logic [31:0]      w_pre32;
  logic [31:0]      w_cmp32;
  logic [31:0]      w_cnt32;

  wire w_ctrl_wr = i_wr && (i_wr_off == OFF_CTRL);

`ifdef TIMER_CASCADE_EN
  logic r_cascade;

  // cascade bit only exists above channel 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cascade <= 1'b0;
    else if (w_ctrl_wr)
      r_cascade <= (CH_IDX > 0) && i_wr_data[CTRL_CASCADE];
  end

  assign w_casc_rd = r_cascade;
`else
  logic w_unused;
  assign w_unused  = i_casc_tick ^ (CH_IDX > 0);
  assign w_casc_rd = 1'b0;
`endif

  // tick source select; a pending reload swallows the tick
  always_comb begin
    w_src = r_oscsel ? i_osc2_tick[r_scale]
                     : i_osc1_tick[r_scale];
`ifdef TIMER_CASCADE_EN
    if (r_cascade)
      w_src = i_casc_tick;
`endif
    w_tick = w_src & r_en & ~r_reload;
  end

  assign w_uflow = w_tick && (r_count == '0);
  assign w_cmp   = w_tick && (r_count == r_compare);
  assign o_uflow = w_uflow;
  assign o_irq   = r_irq;
  assign o_tout  = r_tout;

  // counter, control registers, IRQ pulses and tout level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_oneshot <= 1'b0;
      r_oscsel  <= 1'b0;
      r_scale   <= 3'd0;
      r_preset  <= '0;
      r_compare <= '0;
      r_count   <= '0;
      r_irq     <= 2'b00;
      r_tout    <= 1'b0;
    end else begin
      r_reload <= 1'b0;
      r_irq    <= {w_cmp, w_uflow};
      if (r_reload)
        r_count <= r_preset;
      else if (w_uflow) begin
        if (r_oneshot)
          r_en <= 1'b0;
        else
          r_count <= r_preset;
      end else if (w_tick)
        r_count <= r_count - 1'b1;
      if (w_uflow)
        r_tout <= 1'b1;
      else if (w_cmp)
        r_tout <= 1'b0;
      if (w_ctrl_wr) begin
        r_en      <= i_wr_data[CTRL_EN];
        r_reload  <= i_wr_data[CTRL_RELOAD];
        r_oneshot <= i_wr_data[CTRL_ONESHOT];
        r_oscsel  <= i_wr_data[CTRL_OSCSEL];
      end
      if (i_wr && (i_wr_off == OFF_SCALE))
        r_scale <= i_wr_data[2:0];
      for (int k = 0; k < NB; k++) begin
        if (i_wr && (i_wr_off[1:0] == 2'(k))) begin
          if (i_wr_off[3:2] == GRP_PRESET)
            r_preset[8*k +: 8] <= i_wr_data;
          if (i_wr_off[3:2] == GRP_COMPARE)
            r_compare[8*k +: 8] <= i_wr_data;
        end
      end
    end
  end

  assign w_pre32 = 32'(r_preset);
  assign w_cmp32 = 32'(r_compare);
  assign w_cnt32 = 32'(r_count);

  // register read mux; bytes above CNT_W fall out as zero
  always_comb begin
    w_ctrl = 8'h00;
    w_ctrl[CTRL_EN]      = r_en;
    w_ctrl[CTRL_ONESHOT] = r_oneshot;
    w_ctrl[CTRL_CASCADE] = w_casc_rd;
    w_ctrl[CTRL_OSCSEL]  = r_oscsel;
    o_rd_data = 8'h00;
    unique case (1'b1)
      (i_rd_off == OFF_CTRL):
        o_rd_data = w_ctrl;
      (i_rd_off == OFF_SCALE):
        o_rd_data = {5'd0, r_scale};
      (i_rd_off[3:2] == GRP_PRESET):
        o_rd_data = w_pre32[{i_rd_off[1:0], 3'b000} +: 8];
      (i_rd_off[3:2] == GRP_COMPARE):
        o_rd_data = w_cmp32[{i_rd_off[1:0], 3'b000} +: 8];
      (i_rd_off[3:2] == GRP_COUNT):
        o_rd_data = w_cnt32[{i_rd_off[1:0], 3'b000} +: 8];
      default:
        o_rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/timer_array.sv
// NUM_CH down-counter timers on one CPU bus window, shared prescalers.
// Optional macro TIMER_CASCADE_EN chains channel c to underflows of c-1.
module timer_array
  import timer_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h002030,
  parameter int          NUM_CH    = 3,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce,
  input  logic                rt_ce,
  timer_array_if.slave        bus,
  output logic [2*NUM_CH-1:0] irqs,
  output logic [NUM_CH-1:0]   tout,
  output logic                osc256
);

  logic        r_osc1_en;
  logic        r_osc2_en;
  logic [11:0] r_osc1;
  logic [6:0]  r_osc2;
  logic [7:0]  w_t1;
  logic [7:0]  w_t2;
  logic [23:0] w_off;
  logic [19:0] w_blk;
  logic        w_glb;
  logic        w_wr;
  logic [7:0]  w_rdata;
  logic [7:0]  w_ch_rd [NUM_CH];
  logic [NUM_CH-1:0] w_uflow;
  logic [NUM_CH-1:0] w_casc;
  logic        w_unused;

  assign w_off = bus.bus_address_in - BASE_ADDR;
  assign w_blk = w_off[23:4];
  assign w_glb = (w_blk == 20'(NUM_CH)) && (w_off[3:0] == 4'h0);
  assign w_wr  = clk_ce & bus.bus_write;
  assign w_unused = ^{bus.bus_read, w_uflow};

  // GLOBAL register and the two free-running prescalers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_osc1_en <= 1'b0;
      r_osc2_en <= 1'b0;
      r_osc1    <= 12'd0;
      r_osc2    <= 7'd0;
    end else begin
      if (w_wr && w_glb) begin
        r_osc1_en <= bus.bus_data_in[GLB_OSC1_EN];
        r_osc2_en <= bus.bus_data_in[GLB_OSC2_EN];
      end
      if (clk_ce && r_osc1_en)
        r_osc1 <= r_osc1 + 12'd1;
      if (rt_ce && r_osc2_en)
        r_osc2 <= r_osc2 + 7'd1;
    end
  end

  // per-tap tick strobes
  always_comb begin
    w_t1 = 8'h00;
    w_t2 = 8'h00;
    for (int p = 0; p < 8; p++) begin
      w_t1[p] = clk_ce & r_osc1_en & tick_osc1(r_osc1, 3'(p));
      w_t2[p] = rt_ce & r_osc2_en & tick_osc2(r_osc2, 3'(p));
    end
  end

  assign osc256 = (r_osc2 == 7'h7F);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (c == 0) begin : g_head
      assign w_casc[c] = 1'b0;
    end else begin : g_link
      assign w_casc[c] = w_uflow[c-1];
    end

    timer_channel #(
      .CNT_W  (CNT_W),
      .CH_IDX (c)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_wr        (w_wr && (w_blk == 20'(c))),
      .i_wr_off    (w_off[3:0]),
      .i_wr_data   (bus.bus_data_in),
      .i_rd_off    (w_off[3:0]),
      .o_rd_data   (w_ch_rd[c]),
      .i_osc1_tick (w_t1),
      .i_osc2_tick (w_t2),
      .i_casc_tick (w_casc[c]),
      .o_uflow     (w_uflow[c]),
      .o_irq       (irqs[2*c +: 2]),
      .o_tout      (tout[c])
    );
  end

  // read data: channel block, GLOBAL byte, else zero
  always_comb begin
    w_rdata = 8'h00;
    for (int c = 0; c < NUM_CH; c++)
      if (w_blk == 20'(c))
        w_rdata = w_ch_rd[c];
    if (w_glb)
      w_rdata = {6'd0, r_osc2_en, r_osc1_en};
  end

  assign bus.bus_data_out = w_rdata;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array (3x16-bit main instance, 1x8-bit side instance).
// Cascade checks follow TIMER_CASCADE_EN.
module tb_timer_array;

  localparam logic [23:0] BASE = 24'h002030;
  localparam logic [23:0] CH0  = BASE;
  localparam logic [23:0] CH1  = BASE + 24'h10;
  localparam logic [23:0] CH2  = BASE + 24'h20;
  localparam logic [23:0] GLB  = BASE + 24'h30;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_ce;
  logic       rt_ce;
  logic [5:0] irqs;
  logic [2:0] tout;
  logic       osc256;
  logic [1:0] irqs8;
  logic       tout8;
  logic       osc256_8;

  timer_array_if bus ();
  timer_array_if bus8 ();

  timer_array #(
    .BASE_ADDR (BASE),
    .NUM_CH    (3),
    .CNT_W     (16)
  ) u_dut (
    .clk    (clk),
    .reset  (rst),
    .clk_ce (clk_ce),
    .rt_ce  (rt_ce),
    .bus    (bus),
    .irqs   (irqs),
    .tout   (tout),
    .osc256 (osc256)
  );

  timer_array #(
    .BASE_ADDR (BASE),
    .NUM_CH    (1),
    .CNT_W     (8)
  ) u_dut8 (
    .clk    (clk),
    .reset  (rst),
    .clk_ce (clk_ce),
    .rt_ce  (rt_ce),
    .bus    (bus8),
    .irqs   (irqs8),
    .tout   (tout8),
    .osc256 (osc256_8)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.bus_address_in = a;
    bus.bus_data_in    = v;
    bus.bus_write      = 1'b1;
    @(negedge clk);
    bus.bus_write      = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
    bus.bus_address_in = a;
    bus.bus_read       = 1'b1;
    #1;
    d = bus.bus_data_out;
    bus.bus_read       = 1'b0;
  endtask

  task automatic wr8(input logic [23:0] a, input logic [7:0] v);
    @(negedge clk);
    bus8.bus_address_in = a;
    bus8.bus_data_in    = v;
    bus8.bus_write      = 1'b1;
    @(negedge clk);
    bus8.bus_write      = 1'b0;
  endtask

  task automatic rd8(input logic [23:0] a, output logic [7:0] d);
    bus8.bus_address_in = a;
    #1;
    d = bus8.bus_data_out;
  endtask

  task automatic wait_irq(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irqs[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [7:0] d;
  bit         ok;
  int         n;
  int         t1_cnt [8] = '{2, 1, 1, 0, 0, 3, 3, 2};
  int         t1_irq [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    rst    = 1'b1;
    clk_ce = 1'b1;
    rt_ce  = 1'b0;
    bus.bus_write       = 1'b0;
    bus.bus_read        = 1'b0;
    bus.bus_address_in  = 24'h0;
    bus.bus_data_in     = 8'h0;
    bus8.bus_write      = 1'b0;
    bus8.bus_read       = 1'b0;
    bus8.bus_address_in = 24'h0;
    bus8.bus_data_in    = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_irqs", 32'(irqs), 0);
    chk("rst_tout", 32'(tout), 0);
    chk("rst_osc256", 32'(osc256), 0);
    bus_rd(CH0 + 24'hC, d);
    chk("rst_count", 32'(d), 0);
    rst = 1'b0;

    // 1: auto-reload on osc1 tap 0
    bus_wr(GLB, 8'h01);
    bus_wr(CH0 + 24'h4, 8'h03);
    bus_wr(CH0, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus_rd(CH0 + 24'hC, d);
      if (d == 8'd2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t1_reach2", 32'(ok), 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_rd(CH0 + 24'hC, d);
      chk($sformatf("t1_cnt%0d", k + 1), 32'(d), 32'(t1_cnt[k]));
      chk($sformatf("t1_irq%0d", k + 1), 32'(irqs[0]), 32'(t1_irq[k]));
    end

    // 2: compare IRQ and tout
    bus_wr(CH0 + 24'h8, 8'h01);
    wait_irq(1, 40, ok);
    chk("t2_cmp_seen", 32'(ok), 1);
    bus_rd(CH0 + 24'hC, d);
    chk("t2_cmp_cnt", 32'(d), 0);
    chk("t2_cmp_tout", 32'(tout[0]), 0);
    chk("t2_cmp_nouf", 32'(irqs[0]), 0);
    wait_irq(0, 40, ok);
    chk("t2_uf_seen", 32'(ok), 1);
    chk("t2_uf_tout", 32'(tout[0]), 1);
    chk("t2_uf_nocmp", 32'(irqs[1]), 0);
    bus_rd(CH0 + 24'hC, d);
    chk("t2_uf_cnt", 32'(d), 3);
    bus_wr(CH0 + 24'h8, 8'h00);
    wait_irq(0, 40, ok);
    chk("t2_both_seen", 32'(ok), 1);
    chk("t2_both_cmp", 32'(irqs[1]), 1);
    chk("t2_both_tout", 32'(tout[0]), 1);

    // 3: one-shot
    bus_wr(CH0 + 24'h4, 8'h02);
    bus_wr(CH0, 8'h07);
    @(negedge clk);
    bus_rd(CH0 + 24'hC, d);
    chk("t3_load", 32'(d), 2);
    wait_irq(0, 40, ok);
    chk("t3_uf_seen", 32'(ok), 1);
    bus_rd(CH0, d);
    chk("t3_ctrl", 32'(d), 32'h04);
    bus_rd(CH0 + 24'hC, d);
    chk("t3_cnt0", 32'(d), 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (irqs[0])
        n++;
    end
    chk("t3_single", 32'(n), 0);
    bus_rd(CH0 + 24'hC, d);
    chk("t3_hold", 32'(d), 0);

    // 4: osc2 tap 7 on ch1
    bus_wr(GLB, 8'h03);
    bus_wr(CH1 + 24'h1, 8'h07);
    bus_wr(CH1 + 24'h4, 8'h01);
    bus_wr(CH1, 8'h13);
    @(negedge clk);
    bus_rd(CH1 + 24'hC, d);
    chk("t4_load", 32'(d), 1);
    n = 0;
    for (int s = 1; s <= 256; s++) begin
      rt_ce = 1'b1;
      @(negedge clk);
      rt_ce = 1'b0;
      bus_rd(CH1 + 24'hC, d);
      if (osc256)
        n++;
      if (s == 126)
        chk("t4_osc_126", 32'(osc256), 0);
      if (s == 127) begin
        chk("t4_osc_127", 32'(osc256), 1);
        chk("t4_cnt_127", 32'(d), 1);
      end
      if (s == 128) begin
        chk("t4_osc_128", 32'(osc256), 0);
        chk("t4_cnt_128", 32'(d), 0);
      end
      if (s == 255)
        chk("t4_cnt_255", 32'(d), 0);
      if (s == 256) begin
        chk("t4_cnt_256", 32'(d), 1);
        chk("t4_irq_256", 32'(irqs[2]), 1);
      end
      @(negedge clk);
    end
    chk("t4_osc_high", 32'(n), 2);

    // 5: cascade
`ifdef TIMER_CASCADE_EN
    bus_wr(CH0 + 24'h4, 8'h01);
    bus_wr(CH0, 8'h03);
    bus_wr(CH1 + 24'h4, 8'h02);
    bus_wr(CH1, 8'h0B);
    bus_rd(CH1, d);
    chk("t5_ctrl", 32'(d), 32'h09);
    wait_irq(2, 200, ok);
    chk("t5_first", 32'(ok), 1);
    bus_rd(CH1 + 24'hC, d);
    chk("t5_reload", 32'(d), 2);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (irqs[0])
        n++;
      if (irqs[2]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_second", 32'(ok), 1);
    chk("t5_uf_count", 32'(n), 3);
`else
    bus_wr(CH1, 8'h0B);
    bus_rd(CH1, d);
    chk("t5_casc_off", 32'(d), 32'h01);
`endif
    bus_wr(CH0, 8'h08);
    bus_rd(CH0, d);
    chk("t5_ch0_casc", 32'(d), 0);

    // window edges and byte limits
    bus_rd(GLB, d);
    chk("glb_read", 32'(d), 32'h03);
    bus_rd(BASE - 24'h1, d);
    chk("below_win", 32'(d), 0);
    bus_rd(GLB + 24'h1, d);
    chk("glb_resv", 32'(d), 0);
    bus_rd(BASE + 24'h40, d);
    chk("above_win", 32'(d), 0);
    bus_wr(CH2 + 24'h4, 8'h5A);
    bus_wr(CH2 + 24'h6, 8'hFF);
    bus_rd(CH2 + 24'h4, d);
    chk("w16_b0", 32'(d), 32'h5A);
    bus_rd(CH2 + 24'h6, d);
    chk("w16_b2", 32'(d), 0);
    wr8(BASE + 24'h4, 8'hAB);
    wr8(BASE + 24'h5, 8'hCD);
    rd8(BASE + 24'h4, d);
    chk("w8_b0", 32'(d), 32'hAB);
    rd8(BASE + 24'h5, d);
    chk("w8_b1", 32'(d), 0);
    rd8(BASE + 24'h7, d);
    chk("w8_b3", 32'(d), 0);

    // 6: async reset mid-count
    bus_wr(CH2, 8'h03);
    repeat (7) @(negedge clk);
    chk("t6_pre_tout", 32'(tout[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_irqs", 32'(irqs), 0);
    chk("t6_tout", 32'(tout), 0);
    chk("t6_osc256", 32'(osc256), 0);
    bus_rd(CH2 + 24'hC, d);
    chk("t6_count", 32'(d), 0);
    bus_rd(GLB, d);
    chk("t6_glb", 32'(d), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
